// File: rtl/colocar_bombas.sv
// Bomb placement stage of the 8x8 minesweeper pipeline: a seeded Galois LFSR
// proposes cells and accepts them until the requested number of bombs is placed.
module colocar_bombas (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            num_bombas,
  input  logic [15:0]           semilla,
  input  logic [2:0]            seguro_fila,
  input  logic [2:0]            seguro_col,
  output logic [7:0][7:0][3:0]  matrizBombastic,
  output logic                  ocupado,
  output logic                  listo,
  output logic [1:0]            estado_dbg
);

  // Handshake: start is a level sampled on any rising edge in IDLE or DONE;
  // the board in matrizBombastic is valid exactly while listo is high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    DONE  = 2'd2
  } estado_t;

  localparam logic [15:0] SEMILLA_DEF = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [3:0]  BOMBA       = 4'hF;

  estado_t              r_estado;
  logic [15:0]          r_lfsr;
  logic [5:0]           r_cnt;
  logic [5:0]           r_num;
  logic [2:0]           r_seg_fila;
  logic [2:0]           r_seg_col;
  logic [7:0][7:0][3:0] r_matriz;
  logic                 r_ocupado;
  logic                 r_listo;

  logic [2:0]  w_fila;
  logic [2:0]  w_col;
  logic        w_es_seguro;
  logic        w_ya_bomba;
  logic        w_acepta;
  logic [5:0]  w_cnt_sig;
  logic [15:0] w_lfsr_sig;
  logic [15:0] w_semilla;

  assign w_fila      = r_lfsr[5:3];
  assign w_col       = r_lfsr[2:0];
  assign w_es_seguro = (w_fila == r_seg_fila) && (w_col == r_seg_col);
  assign w_ya_bomba  = (r_matriz[w_fila][w_col] == BOMBA);
  assign w_acepta    = !w_ya_bomba && !w_es_seguro;
  assign w_cnt_sig   = r_cnt + 6'd1;
  assign w_lfsr_sig  = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  assign w_semilla   = (semilla == 16'h0000) ? SEMILLA_DEF : semilla;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_estado   <= IDLE;
      r_lfsr     <= SEMILLA_DEF;
      r_cnt      <= 6'd0;
      r_num      <= 6'd0;
      r_seg_fila <= 3'd0;
      r_seg_col  <= 3'd0;
      r_matriz   <= '0;
      r_ocupado  <= 1'b0;
      r_listo    <= 1'b0;
    end else begin
      case (r_estado)
        IDLE, DONE: begin
          if (start) begin
            r_num      <= num_bombas;
            r_seg_fila <= seguro_fila;
            r_seg_col  <= seguro_col;
            r_lfsr     <= w_semilla;
            r_matriz   <= '0;
            r_cnt      <= 6'd0;
            if (num_bombas == 6'd0) begin
              r_estado  <= DONE;
              r_ocupado <= 1'b0;
              r_listo   <= 1'b1;
            end else begin
              r_estado  <= PLACE;
              r_ocupado <= 1'b1;
              r_listo   <= 1'b0;
            end
          end
        end
        PLACE: begin
          r_lfsr <= w_lfsr_sig;
          if (w_acepta) begin
            r_matriz[w_fila][w_col] <= BOMBA;
            r_cnt                   <= w_cnt_sig;
            if (w_cnt_sig == r_num) begin
              r_estado  <= DONE;
              r_ocupado <= 1'b0;
              r_listo   <= 1'b1;
            end
          end
        end
        default: begin
          r_estado  <= IDLE;
          r_ocupado <= 1'b0;
          r_listo   <= 1'b0;
        end
      endcase
    end
  end

  assign matrizBombastic = r_matriz;
  assign ocupado         = r_ocupado;
  assign listo           = r_listo;
  assign estado_dbg      = r_estado;

endmodule

// File: tb/tb_colocar_bombas.sv
// Directed bench for colocar_bombas: hand-computed boards for known seeds plus a
// small behavioural placement model feeding an expected-board queue.
module tb_colocar_bombas;

  localparam int LIMIT = 20000;

  logic                 clock;
  logic                 rst;
  logic                 start;
  logic [5:0]           num_bombas;
  logic [15:0]          semilla;
  logic [2:0]           seguro_fila;
  logic [2:0]           seguro_col;
  logic [7:0][7:0][3:0] matrizBombastic;
  logic                 ocupado;
  logic                 listo;
  logic [1:0]           estado_dbg;

  int n_chk  = 0;
  int n_pass = 0;
  logic [255:0] exp_q[$];

  colocar_bombas dut (
    .clock           (clock),
    .rst             (rst),
    .start           (start),
    .num_bombas      (num_bombas),
    .semilla         (semilla),
    .seguro_fila     (seguro_fila),
    .seguro_col      (seguro_col),
    .matrizBombastic (matrizBombastic),
    .ocupado         (ocupado),
    .listo           (listo),
    .estado_dbg      (estado_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int n_bombs(input logic [255:0] b);
    int n = 0;
    for (int i = 0; i < 64; i++) if (b[i*4 +: 4] == 4'hF) n++;
    return n;
  endfunction

  function automatic int n_raros(input logic [255:0] b);
    int n = 0;
    for (int i = 0; i < 64; i++) if (b[i*4 +: 4] != 4'hF && b[i*4 +: 4] != 4'h0) n++;
    return n;
  endfunction

  // Behavioural placement: returns the expected board and cycles to completion.
  task automatic modelo(input logic [15:0] seed, input logic [5:0] n, input logic [2:0] f,
                        input logic [2:0] c, output logic [255:0] b, output int cyc);
    logic [15:0] l;
    int cnt;
    int idx;
    l   = (seed == 16'h0) ? 16'hACE1 : seed;
    b   = '0;
    cnt = 0;
    cyc = 0;
    while (cnt < int'(n) && cyc < 100000) begin
      cyc++;
      idx = int'(l[5:0]);
      if (b[idx*4 +: 4] != 4'hF && !(l[5:3] == f && l[2:0] == c)) begin
        b[idx*4 +: 4] = 4'hF;
        cnt++;
      end
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
  endtask

  // driver: issue start, check the accepting edge, then wait for listo
  task automatic run_board(input logic [15:0] seed, input logic [5:0] n, input logic [2:0] f,
                           input logic [2:0] c, input bit pulse,
                           output logic [255:0] board, output int lat);
    int bad;
    @(negedge clock);
    start = 1'b1; semilla = seed; num_bombas = n; seguro_fila = f; seguro_col = c;
    @(negedge clock);
    start = 1'b0;
    chk("clr_on_start", matrizBombastic, '0);
    chk("ocupado_start", ocupado, (n != 6'd0));
    chk("listo_start", listo, (n == 6'd0));
    lat = 0;
    bad = 0;
    while (!listo && lat < LIMIT) begin
      if (!ocupado) bad++;
      if (pulse && lat == 1) begin
        start = 1'b1; semilla = 16'h0F0F; num_bombas = 6'd3;
      end
      if (pulse && lat == 2) start = 1'b0;
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    chk("no_timeout", (lat < LIMIT), 1'b1);
    chk("ocupado_hold", bad, 0);
    chk("ocupado_done", ocupado, 1'b0);
    board = matrizBombastic;
  endtask

  // scoreboard helper: compare a finished board against the model
  task automatic score(input string tag, input logic [15:0] seed, input logic [5:0] n,
                       input logic [2:0] f, input logic [2:0] c,
                       input logic [255:0] board, input int lat);
    logic [255:0] mb;
    int cyc;
    modelo(seed, n, f, c, mb, cyc);
    exp_q.push_back(mb);
    chk({tag, "_board"}, board, exp_q.pop_front());
    chk({tag, "_latency"}, lat, cyc);
    chk({tag, "_count"}, n_bombs(board), int'(n));
    chk({tag, "_codes"}, n_raros(board), 0);
    chk({tag, "_safe"}, board[(int'(f)*8 + int'(c))*4 +: 4], 4'h0);
  endtask

  initial begin
    logic [255:0] b0, b1, b2;
    int lat;
    rst = 1'b1; start = 1'b0; num_bombas = '0; semilla = '0;
    seguro_fila = '0; seguro_col = '0;
    repeat (2) @(negedge clock);
    chk("rst_listo", listo, 1'b0);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_matrix", matrizBombastic, '0);
    chk("rst_state", estado_dbg, 2'd0);
    rst = 1'b0;

    // seed 1: first candidate (0,1) accepted immediately
    run_board(16'h0001, 6'd1, 3'd7, 3'd7, 1'b0, b0, lat);
    chk("s0001_board", b0, 256'hF0);
    chk("s0001_latency", lat, 1);
    chk("s0001_state", estado_dbg, 2'd2);

    // seed 3F: (7,7) is the safe cell, next LFSR B41F gives (3,7)
    run_board(16'h003F, 6'd1, 3'd7, 3'd7, 1'b0, b0, lat);
    chk("s003F_board", b0, 256'hF << 124);
    chk("s003F_latency", lat, 2);

    // full board minus the safe cell
    run_board(16'h1234, 6'd63, 3'd4, 3'd2, 1'b0, b0, lat);
    score("n63", 16'h1234, 6'd63, 3'd4, 3'd2, b0, lat);

    // seed 0 maps to ACE1; repeated seed is deterministic
    run_board(16'h0000, 6'd10, 3'd2, 3'd5, 1'b0, b0, lat);
    score("seed0", 16'hACE1, 6'd10, 3'd2, 3'd5, b0, lat);
    run_board(16'hACE1, 6'd10, 3'd2, 3'd5, 1'b0, b1, lat);
    score("seedACE1", 16'hACE1, 6'd10, 3'd2, 3'd5, b1, lat);
    run_board(16'hACE1, 6'd10, 3'd2, 3'd5, 1'b0, b2, lat);
    score("seedACE1_again", 16'hACE1, 6'd10, 3'd2, 3'd5, b2, lat);

    // N=0 finishes on the accepting edge, then restart with 5
    run_board(16'h2222, 6'd0, 3'd0, 3'd0, 1'b0, b0, lat);
    chk("n0_board", b0, '0);
    chk("n0_latency", lat, 0);
    run_board(16'h2222, 6'd5, 3'd0, 3'd0, 1'b0, b0, lat);
    score("n5", 16'h2222, 6'd5, 3'd0, 3'd0, b0, lat);

    // start during PLACE must be ignored
    run_board(16'h5555, 6'd10, 3'd1, 3'd1, 1'b1, b0, lat);
    score("ignore_start", 16'h5555, 6'd10, 3'd1, 3'd1, b0, lat);

    // reset in the middle of placement discards the partial board
    @(negedge clock);
    start = 1'b1; semilla = 16'h1234; num_bombas = 6'd63; seguro_fila = 3'd4; seguro_col = 3'd2;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("midplace_busy", ocupado, 1'b1);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    chk("midrst_state", estado_dbg, 2'd0);
    chk("midrst_matrix", matrizBombastic, '0);
    chk("midrst_listo", listo, 1'b0);
    chk("midrst_ocupado", ocupado, 1'b0);
    @(negedge clock);
    chk("midrst_stays_idle", estado_dbg, 2'd0);

    // after reset, a fresh run behaves like the first one
    run_board(16'h0001, 6'd1, 3'd7, 3'd7, 1'b0, b0, lat);
    chk("post_rst_board", b0, 256'hF0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
